// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave fronting NUM_REGS memory-mapped registers with byte strobes,
// independent AW/W acceptance, hardware-driven read-only slots and SLVERR/DECERR.
module axi4_lite_regfile_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TOP    = LSB + IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Any set bit above the index field, or an index past the bank, is a decode error.
  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
    logic oor;
    oor = 1'b0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      if (i >= TOP && a[i]) oor = 1'b1;
    end
    if (int'(a[LSB +: IDX_W]) >= NUM_REGS) oor = 1'b1;
    return oor;
  endfunction

  logic                  r_en;
  logic                  r_aw_held;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic                  r_w_held;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_aw_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic [IDX_W-1:0]      w_aw_idx;
  logic                  w_aw_oor;
  logic                  w_aw_ro;
  logic                  w_wr_en;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_ar_oor;
  logic [DATA_WIDTH-1:0] w_rd_vec [NUM_REGS];
  logic                  w_unused_lsb;

  // Handshake rule on every channel: a beat transfers on the rising edge where
  // VALID and READY are both high; a source holds VALID and payload stable until then.
  // r_en keeps every READY low while reset is applied and for the edge after it.
  assign AWREADY = r_en && !r_aw_held && !r_bvalid;
  assign WREADY  = r_en && !r_w_held  && !r_bvalid;
  assign ARREADY = r_en && !r_rvalid;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;
  assign w_ar_hs = ARVALID && ARREADY;

  // A beat arriving this cycle is used directly so the response follows on the next edge.
  assign w_aw_addr = r_aw_held ? r_aw_addr : AWADDR;
  assign w_wdata   = r_w_held  ? r_wdata   : WDATA;
  assign w_wstrb   = r_w_held  ? r_wstrb   : WSTRB;
  assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;

  assign w_aw_idx = w_aw_addr[LSB +: IDX_W];
  assign w_aw_oor = addr_oor(w_aw_addr);
  assign w_aw_ro  = !w_aw_oor && RO_MASK[w_aw_idx];
  assign w_wr_en  = w_commit && !w_aw_oor && !w_aw_ro;

  assign w_ar_idx = ARADDR[LSB +: IDX_W];
  assign w_ar_oor = addr_oor(ARADDR);

  assign w_unused_lsb = ^{AWADDR[LSB-1:0], ARADDR[LSB-1:0], r_aw_addr[LSB-1:0]};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (RO_MASK[g]) begin : g_ro
      assign w_rd_vec[g] = hw_in[g*DATA_WIDTH +: DATA_WIDTH];
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] r_val;
      logic                  w_unused_hw;

      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          r_val <= RESET_VAL;
        end else if (w_wr_en && (w_aw_idx == IDX_W'(g))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_wstrb[b]) r_val[b*8 +: 8] <= w_wdata[b*8 +: 8];
          end
        end
      end

      assign w_unused_hw = ^hw_in[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_rd_vec[g] = r_val;
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_val;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_en <= 1'b0;
    end else begin
      r_en <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        if (w_aw_oor) begin
          r_bresp <= RESP_DECERR;
        end else if (w_aw_ro) begin
          r_bresp <= RESP_SLVERR;
        end else begin
          r_bresp <= RESP_OKAY;
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_addr <= AWADDR;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= WDATA;
          r_wstrb  <= WSTRB;
        end
        if (r_bvalid && BREADY) r_bvalid <= 1'b0;
      end
    end
  end

  // Non-blocking update means a same-edge write is not visible to this read.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      if (w_ar_oor) begin
        r_rdata <= '0;
        r_rresp <= RESP_DECERR;
      end else begin
        r_rdata <= w_rd_vec[w_ar_idx];
        r_rresp <= RESP_OKAY;
      end
    end else if (r_rvalid && RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule
